msrv32_wb_pipe_reg: RTL and testbench

- Stage-2 pipeline register directly upstream of the write-enable generator.
- Captures the decoded instruction's write-back payload and its RF/CSR write requests, holds them on halt, and inserts bubbles on flush.
- Produces the registered rf/csr write enables that the write-enable generator gates with flush.
- Guarantees each instruction asserts its write enables for exactly one cycle and produces a retire pulse for the instret counter.

---
 rtl/msrv32_wb_pipe_reg.sv | 180 ++++++++++++++++++
 tb/tb_msrv32_wb_pipe_reg.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv32_wb_pipe_reg.sv
// msrv32_wb_pipe_reg
//   Stage-2 pipeline register feeding the write-enable generator. Captures the
//   write-back payload and RF/CSR write requests, holds them on halt, loads
//   bubbles on flush, and makes sure every instruction presents its write
//   enables and its retire pulse for exactly one cycle.
//
// Parameters:
//   FLUSH_CYCLES  bubble-loading edges per flush, flush edge included (1..7)
//
// Optional feature (macro MSRV32_WB_STALL_CNT_EN):
//   adds stall_cnt_out, a wrapping count of halted edges holding a valid
//   instruction.
//
// Ports:
//   ms_riscv32_mp_clk_in    core clock, rising edge
//   ms_riscv32_mp_rst_n_in  asynchronous active-low reset
//   hlt_in / flush_in       halt (payload holds) / flush (wins over halt)
//   valid_in, rd_addr_in, rf_wr_en_in, csr_wr_en_in, csr_addr_in,
//   wb_mux_sel_in, alu_result_in, pc_plus_4_in   stage-1 instruction payload
//   *_reg_out               registered payload and write requests
//   instret_inc_out         one-cycle retire pulse
//   stall_cnt_out           stall counter (only with MSRV32_WB_STALL_CNT_EN)

module msrv32_wb_pipe_reg #(
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_n_in,
  input  logic        hlt_in,
  input  logic        flush_in,
  input  logic        valid_in,
  input  logic [4:0]  rd_addr_in,
  input  logic        rf_wr_en_in,
  input  logic        csr_wr_en_in,
  input  logic [11:0] csr_addr_in,
  input  logic [2:0]  wb_mux_sel_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] pc_plus_4_in,
  output logic        valid_reg_out,
  output logic        rf_wr_en_reg_out,
  output logic        csr_wr_en_reg_out,
  output logic [4:0]  rd_addr_reg_out,
  output logic [11:0] csr_addr_reg_out,
  output logic [2:0]  wb_mux_sel_reg_out,
  output logic [31:0] alu_result_reg_out,
  output logic [31:0] pc_plus_4_reg_out,
`ifdef MSRV32_WB_STALL_CNT_EN
  output logic [31:0] stall_cnt_out,
`endif
  output logic        instret_inc_out
);

  localparam bit          MultiFlush = (FLUSH_CYCLES > 1);
  localparam logic [2:0]  RemReload  = 3'(FLUSH_CYCLES - 1);

  typedef enum logic [0:0] {StRun, StFlush} state_e;

  state_e      state_q, state_d;
  logic [2:0]  rem_q, rem_d;
  logic        valid_q, valid_d;
  logic        rf_wr_en_q, rf_wr_en_d;
  logic        csr_wr_en_q, csr_wr_en_d;
  logic        issued_q, issued_d;
  logic        load;

  logic [4:0]  rd_addr_q;
  logic [11:0] csr_addr_q;
  logic [2:0]  wb_mux_sel_q;
  logic [31:0] alu_result_q;
  logic [31:0] pc_plus_4_q;

  // Control next-state. A bubble clears valid/enables but leaves the payload
  // untouched; payload only moves on a real load.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    valid_d     = valid_q;
    rf_wr_en_d  = rf_wr_en_q;
    csr_wr_en_d = csr_wr_en_q;
    issued_d    = issued_q;
    load        = 1'b0;

    if (flush_in) begin
      valid_d     = 1'b0;
      rf_wr_en_d  = 1'b0;
      csr_wr_en_d = 1'b0;
      issued_d    = 1'b0;
      if (MultiFlush) begin
        state_d = StFlush;
        rem_d   = RemReload;
      end else begin
        state_d = StRun;
        rem_d   = 3'd0;
      end
    end else if (state_q == StFlush) begin
      valid_d     = 1'b0;
      rf_wr_en_d  = 1'b0;
      csr_wr_en_d = 1'b0;
      issued_d    = 1'b0;
      rem_d       = rem_q - 3'd1;
      if (rem_q <= 3'd1) begin
        state_d = StRun;
        rem_d   = 3'd0;
      end
    end else if (hlt_in) begin
      // Once the first held cycle has gone by, the instruction counts as
      // issued so its enables and retire pulse are not repeated.
      issued_d = valid_q;
    end else begin
      load        = 1'b1;
      valid_d     = valid_in;
      rf_wr_en_d  = valid_in & rf_wr_en_in & (rd_addr_in != 5'd0);
      csr_wr_en_d = valid_in & csr_wr_en_in;
      issued_d    = 1'b0;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state_q     <= StRun;
      rem_q       <= 3'd0;
      valid_q     <= 1'b0;
      rf_wr_en_q  <= 1'b0;
      csr_wr_en_q <= 1'b0;
      issued_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      valid_q     <= valid_d;
      rf_wr_en_q  <= rf_wr_en_d;
      csr_wr_en_q <= csr_wr_en_d;
      issued_q    <= issued_d;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      rd_addr_q    <= 5'd0;
      csr_addr_q   <= 12'd0;
      wb_mux_sel_q <= 3'd0;
      alu_result_q <= 32'd0;
      pc_plus_4_q  <= 32'd0;
    end else if (load) begin
      rd_addr_q    <= rd_addr_in;
      csr_addr_q   <= csr_addr_in;
      wb_mux_sel_q <= wb_mux_sel_in;
      alu_result_q <= alu_result_in;
      pc_plus_4_q  <= pc_plus_4_in;
    end
  end

`ifdef MSRV32_WB_STALL_CNT_EN
  logic [31:0] stall_cnt_q;
  logic        stall_inc;

  assign stall_inc = (state_q == StRun) & hlt_in & ~flush_in & valid_q;

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      stall_cnt_q <= 32'd0;
    end else if (stall_inc) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_out = stall_cnt_q;
`endif

  assign valid_reg_out      = valid_q;
  assign rf_wr_en_reg_out   = rf_wr_en_q & ~issued_q;
  assign csr_wr_en_reg_out  = csr_wr_en_q & ~issued_q;
  assign rd_addr_reg_out    = rd_addr_q;
  assign csr_addr_reg_out   = csr_addr_q;
  assign wb_mux_sel_reg_out = wb_mux_sel_q;
  assign alu_result_reg_out = alu_result_q;
  assign pc_plus_4_reg_out  = pc_plus_4_q;
  // A flush in the instruction's first cycle kills its retirement.
  assign instret_inc_out    = valid_q & ~issued_q & ~flush_in;

endmodule

// File: tb/tb_msrv32_wb_pipe_reg.sv
// Self-checking bench for msrv32_wb_pipe_reg, built with FLUSH_CYCLES = 3.
// Expected output vectors are queued as stimulus is driven and compared one
// cycle later against the registered outputs.

module tb_msrv32_wb_pipe_reg;

  localparam int unsigned FC = 3;

  typedef struct packed {
    logic        v;
    logic [4:0]  rd;
    logic        rfw;
    logic        csrw;
    logic [11:0] ca;
    logic [2:0]  sel;
    logic [31:0] alu;
    logic [31:0] pc;
    logic        hlt;
    logic        fl;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hlt_in = 1'b0, flush_in = 1'b0, valid_in = 1'b0;
  logic [4:0]  rd_addr_in = '0;
  logic        rf_wr_en_in = 1'b0, csr_wr_en_in = 1'b0;
  logic [11:0] csr_addr_in = '0;
  logic [2:0]  wb_mux_sel_in = '0;
  logic [31:0] alu_result_in = '0, pc_plus_4_in = '0;

  logic        valid_reg_out, rf_wr_en_reg_out, csr_wr_en_reg_out, instret_inc_out;
  logic [4:0]  rd_addr_reg_out;
  logic [11:0] csr_addr_reg_out;
  logic [2:0]  wb_mux_sel_reg_out;
  logic [31:0] alu_result_reg_out, pc_plus_4_reg_out;
`ifdef MSRV32_WB_STALL_CNT_EN
  logic [31:0] stall_cnt_out;
`endif

  int vectors = 0;
  int fails = 0;
  logic [87:0] exp_q[$];
  logic [87:0] got, want;

  always #5 clk = ~clk;

  msrv32_wb_pipe_reg #(.FLUSH_CYCLES(FC)) dut (
    .ms_riscv32_mp_clk_in  (clk),
    .ms_riscv32_mp_rst_n_in(rst_n),
    .hlt_in                (hlt_in),
    .flush_in              (flush_in),
    .valid_in              (valid_in),
    .rd_addr_in            (rd_addr_in),
    .rf_wr_en_in           (rf_wr_en_in),
    .csr_wr_en_in          (csr_wr_en_in),
    .csr_addr_in           (csr_addr_in),
    .wb_mux_sel_in         (wb_mux_sel_in),
    .alu_result_in         (alu_result_in),
    .pc_plus_4_in          (pc_plus_4_in),
    .valid_reg_out         (valid_reg_out),
    .rf_wr_en_reg_out      (rf_wr_en_reg_out),
    .csr_wr_en_reg_out     (csr_wr_en_reg_out),
    .rd_addr_reg_out       (rd_addr_reg_out),
    .csr_addr_reg_out      (csr_addr_reg_out),
    .wb_mux_sel_reg_out    (wb_mux_sel_reg_out),
    .alu_result_reg_out    (alu_result_reg_out),
    .pc_plus_4_reg_out     (pc_plus_4_reg_out),
`ifdef MSRV32_WB_STALL_CNT_EN
    .stall_cnt_out         (stall_cnt_out),
`endif
    .instret_inc_out       (instret_inc_out)
  );

  function automatic stim_t mk(input logic v, input logic [4:0] rd, input logic rfw,
                               input logic csrw, input logic [11:0] ca,
                               input logic [2:0] sel, input logic [31:0] alu,
                               input logic [31:0] pc, input logic hlt, input logic fl);
    stim_t s;
    s.v = v; s.rd = rd; s.rfw = rfw; s.csrw = csrw; s.ca = ca;
    s.sel = sel; s.alu = alu; s.pc = pc; s.hlt = hlt; s.fl = fl;
    return s;
  endfunction

  // Expected output vector: flags plus the payload of instruction p.
  function automatic logic [87:0] ev(input logic v, input logic rf, input logic csr,
                                     input logic inst, input stim_t p);
    return {v, rf, csr, inst, p.rd, p.ca, p.sel, p.alu, p.pc};
  endfunction

  function automatic logic [87:0] obs();
    return {valid_reg_out, rf_wr_en_reg_out, csr_wr_en_reg_out, instret_inc_out,
            rd_addr_reg_out, csr_addr_reg_out, wb_mux_sel_reg_out,
            alu_result_reg_out, pc_plus_4_reg_out};
  endfunction

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic apply(input stim_t s);
    valid_in = s.v; rd_addr_in = s.rd; rf_wr_en_in = s.rfw; csr_wr_en_in = s.csrw;
    csr_addr_in = s.ca; wb_mux_sel_in = s.sel; alu_result_in = s.alu;
    pc_plus_4_in = s.pc; hlt_in = s.hlt; flush_in = s.fl;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    stim_t idle;
    idle = '0;
    rst_n = 1'b0;
    apply(idle);
    @(negedge clk);
    rst_n = 1'b1;
    apply(idle);
  endtask

  task automatic test_reset();
    #2;
    got = obs();
    vectors++;
    if (got !== 88'd0) begin
      fails++;
      $display("FAIL reset: got %h want %h", got, 88'd0);
    end
`ifdef MSRV32_WB_STALL_CNT_EN
    vectors++;
    if (stall_cnt_out !== 32'd0) begin
      fails++;
      $display("FAIL reset_stall: got %0d want 0", stall_cnt_out);
    end
`endif
  endtask

  task automatic test_load_halt();
    stim_t s0, junk, s1;
    do_reset();
    s0 = mk(1, 5'd5, 1, 0, 12'h000, 3'd1, 32'h1234, 32'h104, 0, 0);
    exp_q.push_back(ev(1, 1, 0, 1, s0));
    apply(s0);
    got = obs(); want = exp_q.pop_front(); vectors++;
    if (got !== want) begin
      fails++; $display("FAIL load: got %h want %h", got, want);
    end
    junk = mk(1, 5'd7, 1, 1, 12'h5a5, 3'd2, 32'hdead, 32'h200, 1, 0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(ev(1, 0, 0, 0, s0));
      apply(junk);
      got = obs(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        fails++; $display("FAIL halt%0d: got %h want %h", i, got, want);
      end
    end
`ifdef MSRV32_WB_STALL_CNT_EN
    vectors++;
    if (stall_cnt_out !== 32'd3) begin
      fails++; $display("FAIL stall_cnt: got %0d want 3", stall_cnt_out);
    end
`endif
    s1 = mk(1, 5'd9, 0, 1, 12'h341, 3'd3, 32'h55, 32'h108, 0, 0);
    exp_q.push_back(ev(1, 0, 1, 1, s1));
    apply(s1);
    got = obs(); want = exp_q.pop_front(); vectors++;
    if (got !== want) begin
      fails++; $display("FAIL resume: got %h want %h", got, want);
    end
  endtask

  task automatic test_x0();
    stim_t s[3];
    logic [87:0] e[3];
    do_reset();
    s[0] = mk(1, 5'd0, 1, 0, 12'h001, 3'd1, 32'haaaa, 32'h20, 0, 0);
    e[0] = ev(1, 0, 0, 1, s[0]);
    s[1] = mk(0, 5'd3, 1, 1, 12'h002, 3'd2, 32'hbbbb, 32'h24, 0, 0);
    e[1] = ev(0, 0, 0, 0, s[1]);
    s[2] = mk(1, 5'd31, 1, 1, 12'h003, 3'd5, 32'hcccc, 32'h28, 0, 0);
    e[2] = ev(1, 1, 1, 1, s[2]);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(e[i]);
      apply(s[i]);
      got = obs(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        fails++; $display("FAIL x0_%0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_flush();
    stim_t s[10];
    logic [87:0] e[10];
    do_reset();
    for (int i = 0; i < 10; i++)
      s[i] = mk(1, 5'(i + 1), 1, 0, 12'(i), 3'(i), 32'h1000 + 32'(i), 32'h400 + 32'(i * 4),
                0, 0);
    s[1].fl = 1; s[2].hlt = 1; s[3].hlt = 1;
    s[5].fl = 1; s[6].fl = 1;
    e[0] = ev(1, 1, 0, 1, s[0]);
    e[1] = ev(0, 0, 0, 0, s[0]);
    e[2] = ev(0, 0, 0, 0, s[0]);
    e[3] = ev(0, 0, 0, 0, s[0]);
    e[4] = ev(1, 1, 0, 1, s[4]);
    // Second flush re-triggered inside FLUSH: four bubbles in total.
    for (int i = 5; i < 9; i++) e[i] = ev(0, 0, 0, 0, s[4]);
    e[9] = ev(1, 1, 0, 1, s[9]);
    for (int i = 0; i < 10; i++) begin
      exp_q.push_back(e[i]);
      apply(s[i]);
      got = obs(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        fails++; $display("FAIL flush_%0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_csr_flush_halt();
    stim_t c, f, n[3];
    logic [87:0] e[3];
    do_reset();
    c = mk(1, 5'd0, 0, 1, 12'h300, 3'd4, 32'h77, 32'h10, 0, 0);
    exp_q.push_back(ev(1, 0, 1, 1, c));
    apply(c);
    got = obs(); want = exp_q.pop_front(); vectors++;
    if (got !== want) begin
      fails++; $display("FAIL csr_load: got %h want %h", got, want);
    end
    // Flush in the fresh instruction's first cycle: no retire, enable still out.
    flush_in = 1'b1;
    #1;
    vectors++;
    if (instret_inc_out !== 1'b0 || csr_wr_en_reg_out !== 1'b1) begin
      fails++;
      $display("FAIL csr_coincident: got instret=%b csr_en=%b want instret=0 csr_en=1",
               instret_inc_out, csr_wr_en_reg_out);
    end
    f = mk(1, 5'd3, 1, 1, 12'h305, 3'd1, 32'h88, 32'h14, 1, 1);
    exp_q.push_back(ev(0, 0, 0, 0, c));
    apply(f);
    got = obs(); want = exp_q.pop_front(); vectors++;
    if (got !== want) begin
      fails++; $display("FAIL csr_flush: got %h want %h", got, want);
    end
    for (int i = 0; i < 3; i++)
      n[i] = mk(1, 5'd4, 1, 0, 12'h111, 3'd2, 32'h900 + 32'(i), 32'h18, 0, 0);
    e[0] = ev(0, 0, 0, 0, c);
    e[1] = ev(0, 0, 0, 0, c);
    e[2] = ev(1, 1, 0, 1, n[2]);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(e[i]);
      apply(n[i]);
      got = obs(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        fails++; $display("FAIL csr_after_%0d: got %h want %h", i, got, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t a, fl, h, b;
    do_reset();
    a  = mk(1, 5'd6, 1, 1, 12'h342, 3'd1, 32'h600, 32'h60, 0, 0);
    fl = mk(1, 5'd7, 1, 0, 12'h343, 3'd2, 32'h700, 32'h64, 0, 1);
    b  = mk(1, 5'd8, 1, 0, 12'h344, 3'd3, 32'h800, 32'h68, 0, 0);
    h  = mk(1, 5'd9, 1, 1, 12'h345, 3'd6, 32'h900, 32'h6c, 1, 0);
    apply(a);
    exp_q.push_back(ev(0, 0, 0, 0, a));
    apply(fl);
    got = obs(); want = exp_q.pop_front(); vectors++;
    if (got !== want) begin
      fails++; $display("FAIL midflush_bubble: got %h want %h", got, want);
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    got = obs(); vectors++;
    if (got !== 88'd0) begin
      fails++; $display("FAIL midflush_reset: got %h want %h", got, 88'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(ev(1, 1, 0, 1, b));
    apply(b);
    got = obs(); want = exp_q.pop_front(); vectors++;
    if (got !== want) begin
      fails++; $display("FAIL midflush_release: got %h want %h", got, want);
    end
    apply(h);
    apply(h);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    got = obs(); vectors++;
    if (got !== 88'd0) begin
      fails++; $display("FAIL midstall_reset: got %h want %h", got, 88'd0);
    end
`ifdef MSRV32_WB_STALL_CNT_EN
    vectors++;
    if (stall_cnt_out !== 32'd0) begin
      fails++; $display("FAIL midstall_cnt: got %0d want 0", stall_cnt_out);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.push_back(ev(1, 1, 1, 1, a));
    apply(a);
    got = obs(); want = exp_q.pop_front(); vectors++;
    if (got !== want) begin
      fails++; $display("FAIL midstall_release: got %h want %h", got, want);
    end
  endtask

  task automatic test_back_to_back();
    stim_t s;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      s = mk(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 12'($urandom), 3'($urandom), $urandom, $urandom, 0, 0);
      if (i == 0) s.v = 1'b1;
      exp_q.push_back(ev(s.v, s.v & s.rfw & (s.rd != 5'd0), s.v & s.csrw, s.v, s));
      apply(s);
      got = obs(); want = exp_q.pop_front(); vectors++;
      if (got !== want) begin
        fails++; $display("FAIL b2b_%0d: got %h want %h", i, got, want);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load_halt();
    test_x0();
    test_flush();
    test_csr_flush_halt();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
